// File: rtl/sequential_sign_magnitude_multiplier_pkg.sv
// Shared types and constants for the sequential sign-magnitude multiplier.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } mult_state_t;

  localparam int DEFAULT_WORD_LENGTH = 16;
  localparam int DEFAULT_CNT_WIDTH   = $clog2(DEFAULT_WORD_LENGTH + 1);

endpackage

// File: rtl/sequential_sign_magnitude_multiplier_datapath.sv
// Shift-add datapath: accumulator, conditional adder, right shifter and output negator.
module shift_add_datapath
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       step,
  input  logic                       finish,
  input  logic [WORD_LENGTH-1:0]     mcand_mag,
  input  logic                       mcand_sign,
  input  logic [WORD_LENGTH-1:0]     mplier_mag,
  input  logic                       mplier_sign,
  output logic [2*WORD_LENGTH-1:0]   product
);

  localparam int W = WORD_LENGTH;

  logic [2*W-1:0] acc;
  logic [W-1:0]   mcand;
  logic           res_sign;

  logic [W:0]     addend;
  logic [W:0]     sum;
  logic [2*W-1:0] acc_shifted;
  logic [2*W-1:0] acc_neg;

  // The carry out of the upper-half add becomes the new MSB after the shift.
  always_comb begin
    addend      = acc[0] ? {1'b0, mcand} : '0;
    sum         = {1'b0, acc[2*W-1:W]} + addend;
    acc_shifted = {sum, acc[W-1:1]};
    acc_neg     = ~acc + {{(2*W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      res_sign <= 1'b0;
      product  <= '0;
    end else begin
      if (load) begin
        acc      <= {{W{1'b0}}, mplier_mag};
        mcand    <= mcand_mag;
        res_sign <= mcand_sign ^ mplier_sign;
      end else if (step) begin
        acc <= acc_shifted;
      end
      if (finish) begin
        product <= res_sign ? acc_neg : acc;
      end
    end
  end

endmodule

// File: rtl/sequential_sign_magnitude_multiplier.sv
// Sequential sign-magnitude multiplier: FSM, iteration counter and start/ready/done handshake.
module sequential_sign_magnitude_multiplier
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     Multiplicand_Mag,
  input  logic                       Multiplicand_Sign,
  input  logic [WORD_LENGTH-1:0]     Multiplier_Mag,
  input  logic                       Multiplier_Sign,
  output logic                       ready,
  output logic                       done,
  output logic [2*WORD_LENGTH-1:0]   Product,
  output logic [1:0]                 state_dbg
);

  localparam int CNT_W = $clog2(WORD_LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_LENGTH - 1);

  mult_state_t      state, next_state;
  logic [CNT_W-1:0] counter;
  logic             load, step, finish;

  // Handshake: a request transfers on a rising edge where start=1 and ready=1;
  // start with ready=0 is dropped. done is a one-cycle pulse marking Product updated,
  // and ready is already 1 in that cycle, so a new start may transfer then.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      done    <= 1'b0;
    end else begin
      state <= next_state;
      done  <= finish;
      if (load) begin
        counter <= '0;
      end else if (step) begin
        counter <= counter + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (counter == LAST_ITER) begin
          next_state = SIGN;
        end
      end
      SIGN: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign state_dbg = state;

  shift_add_datapath #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .finish      (finish),
    .mcand_mag   (Multiplicand_Mag),
    .mcand_sign  (Multiplicand_Sign),
    .mplier_mag  (Multiplier_Mag),
    .mplier_sign (Multiplier_Sign),
    .product     (Product)
  );

endmodule

// File: tb/tb_sequential_sign_magnitude_multiplier.sv
// Directed and randomized checks of the sequential sign-magnitude multiplier at W=8.
module tb_sequential_sign_magnitude_multiplier;

  localparam int W = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  mcand_mag;
  logic          mcand_sign;
  logic [W-1:0]  mplier_mag;
  logic          mplier_sign;
  logic          ready;
  logic          done;
  logic [2*W-1:0] product;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;

  sequential_sign_magnitude_multiplier #(
    .WORD_LENGTH(W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .Multiplicand_Mag  (mcand_mag),
    .Multiplicand_Sign (mcand_sign),
    .Multiplier_Mag    (mplier_mag),
    .Multiplier_Sign   (mplier_sign),
    .ready             (ready),
    .done              (done),
    .Product           (product),
    .state_dbg         (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation and waits (bounded) for done; lat is the edge count after the
  // capture edge at which done was seen, or -1 on timeout.
  task automatic do_op(input logic [W-1:0] a_mag, input logic a_sign,
                       input logic [W-1:0] b_mag, input logic b_sign,
                       output logic [2*W-1:0] prod, output int lat);
    @(negedge clk);
    mcand_mag   = a_mag;
    mcand_sign  = a_sign;
    mplier_mag  = b_mag;
    mplier_sign = b_sign;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    prod  = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat  = k;
        prod = product;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mcand_mag = '0; mcand_sign = 1'b0; mplier_mag = '0; mplier_sign = 1'b0;
    #12;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || product !== 16'h0000 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b product=%h state=%0d, need 1 0 0000 0",
               ready, done, product, state_dbg);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b done=%b, need 1 0", ready, done);
    end
  endtask

  task automatic test_vectors();
    logic [2*W-1:0] p;
    int lat;
    logic [W-1:0] am [4] = '{8'd7, 8'd128, 8'd0, 8'd128};
    logic         as [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] bm [4] = '{8'd3, 8'd128, 8'd5, 8'd127};
    logic         bs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0]  ex [4] = '{16'hFFEB, 16'h4000, 16'h0000, 16'hC080};
    for (int i = 0; i < 4; i++) begin
      do_op(am[i], as[i], bm[i], bs[i], p, lat);
      checks++;
      if (p !== ex[i] || lat != 9) begin
        errors++;
        $display("FAIL vector_%0d: product=%h latency=%0d, need %h latency 9", i, p, lat, ex[i]);
      end
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("FAIL vector_%0d_ready: ready=%b, need 1", i, ready);
      end
    end
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    int done_edge = -1;
    logic [2*W-1:0] p = 'x;
    @(negedge clk);
    mcand_mag = 8'd10; mcand_sign = 1'b0; mplier_mag = 8'd11; mplier_sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int e = 1; e <= 15; e++) begin
      start = (e == 3 || e == 5);
      if (start) begin
        mcand_mag = 8'd99; mcand_sign = 1'b1; mplier_mag = 8'd77; mplier_sign = 1'b0;
      end
      checks++;
      if (e <= 9 && ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready_e%0d: ready=%b, need 0", e, ready);
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        done_edge = e;
        p = product;
      end
    end
    start = 1'b0;
    checks++;
    if (n_done != 1 || done_edge != 9 || p !== 16'h006E) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d edge=%0d product=%h, need 1 9 006E",
               n_done, done_edge, p);
    end
    checks++;
    if (product !== 16'h006E) begin
      errors++;
      $display("FAIL ignore_start_hold: product=%h, need 006E", product);
    end
  endtask

  task automatic test_async_reset();
    int n_done = 0;
    logic [2*W-1:0] p;
    int lat;
    @(negedge clk);
    mcand_mag = 8'd20; mcand_sign = 1'b0; mplier_mag = 8'd30; mplier_sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (product !== 16'h006E) begin
      errors++;
      $display("FAIL hold_while_busy: product=%h, need 006E", product);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: ready=%b done=%b product=%h, need 1 0 0000",
               ready, done, product);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL aborted_done: dones=%0d, need 0", n_done);
    end
    do_op(8'd12, 1'b1, 8'd12, 1'b0, p, lat);
    checks++;
    if (p !== 16'hFF70 || lat != 9) begin
      errors++;
      $display("FAIL after_reset_op: product=%h latency=%0d, need FF70 latency 9", p, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    int edges[$];
    logic [15:0] e_val;
    exp_q.push_back(16'hFFE2);
    exp_q.push_back(16'h0051);
    @(negedge clk);
    mcand_mag = 8'd5; mcand_sign = 1'b1; mplier_mag = 8'd6; mplier_sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mcand_mag = 8'd9; mcand_sign = 1'b1; mplier_mag = 8'd9; mplier_sign = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      start = (e <= 10);
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        edges.push_back(e);
        checks++;
        e_val = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        if (product !== e_val) begin
          errors++;
          $display("FAIL b2b_product_e%0d: product=%h, need %h", e, product, e_val);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (edges.size() != 2 || edges[0] != 9 || edges[1] != 19) begin
      errors++;
      $display("FAIL b2b_timing: done count=%0d first=%0d second=%0d, need 2 at 9 and 19",
               edges.size(), (edges.size() > 0) ? edges[0] : -1,
               (edges.size() > 1) ? edges[1] : -1);
    end
  endtask

  task automatic test_random();
    int a, b, lat;
    logic [2*W-1:0] p, exp_p;
    logic [W-1:0] am, bm;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      am = W'((a < 0) ? -a : a);
      bm = W'((b < 0) ? -b : b);
      exp_p = 16'(a * b);
      do_op(am, a < 0, bm, b < 0, p, lat);
      checks++;
      if (p !== exp_p || lat != 9) begin
        errors++;
        $display("FAIL random_%0d: %0d*%0d product=%h latency=%0d, need %h latency 9",
                 i, a, b, p, lat, exp_p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
